// File: rtl/csr_reg_if.sv
// csr_reg_if: execute-stage and interrupt-controller CSR bus bundle.
// master drives requests; slave is the CSR file.
interface csr_reg_if;
   logic        ex_wr_en_i;
   logic [31:0] ex_wr_addr_i;
   logic [31:0] ex_wr_data_i;
   logic [31:0] ex_rd_addr_i;
   logic [31:0] ex_rd_data_o;
   logic        clint_wr_en_i;
   logic [31:0] clint_wr_addr_i;
   logic [31:0] clint_wr_data_i;
   logic        clint_wr_privilege_en_i;
   logic [1:0]  clint_wr_privilege_ctrl_i;
   logic [31:0] clint_mtvec_o;
   logic [31:0] clint_mepc_o;
   logic [31:0] clint_mstatus_o;
   logic [1:0]  privilege_o;
   logic        global_int_en_o;

   modport master (
      output ex_wr_en_i,
      output ex_wr_addr_i,
      output ex_wr_data_i,
      output ex_rd_addr_i,
      output clint_wr_en_i,
      output clint_wr_addr_i,
      output clint_wr_data_i,
      output clint_wr_privilege_en_i,
      output clint_wr_privilege_ctrl_i,
      input  ex_rd_data_o,
      input  clint_mtvec_o,
      input  clint_mepc_o,
      input  clint_mstatus_o,
      input  privilege_o,
      input  global_int_en_o
   );

   modport slave (
      input  ex_wr_en_i,
      input  ex_wr_addr_i,
      input  ex_wr_data_i,
      input  ex_rd_addr_i,
      input  clint_wr_en_i,
      input  clint_wr_addr_i,
      input  clint_wr_data_i,
      input  clint_wr_privilege_en_i,
      input  clint_wr_privilege_ctrl_i,
      output ex_rd_data_o,
      output clint_mtvec_o,
      output clint_mepc_o,
      output clint_mstatus_o,
      output privilege_o,
      output global_int_en_o
   );
endinterface

// File: rtl/csr_reg.sv
// csr_reg: machine-mode CSR file with two write ports,
// 64-bit cycle counter and write-through read bypass.
module csr_reg (
   input logic      sys_clk,
   input logic      sys_reset,
   csr_reg_if.slave bus
);
   localparam int NREG      = 8;
   localparam int I_MSTATUS = 0;
   localparam int I_MIE     = 1;
   localparam int I_MTVEC   = 2;
   localparam int I_MSCR    = 3;
   localparam int I_MEPC    = 4;
   localparam int I_MCAUSE  = 5;
   localparam int I_MCYCLE  = 6;
   localparam int I_MCYCLEH = 7;

   localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

   logic [31:0] r_csr [NREG];
   logic [1:0]  r_priv;

   logic            w_cwe;
   logic            w_ewe;
   logic [11:0]     w_ca;
   logic [11:0]     w_ea;
   logic [11:0]     w_ra;
   logic [31:0]     w_cd;
   logic [31:0]     w_ed;
   logic [NREG-1:0] w_c_sel;
   logic [NREG-1:0] w_e_sel;
   logic [NREG-1:0] w_rsel;
   logic [31:0]     w_byp [NREG];
   logic [31:0]     w_rd;
   logic            w_lo_wr;
   logic            w_hi_wr;
   logic            w_carry;
   logic            w_unused_hi;

   function automatic logic [NREG-1:0] f_dec(
      input logic [11:0] a
   );
      logic [NREG-1:0] s;
      s = '0;
      unique case (a)
         12'h300: s[I_MSTATUS] = 1'b1;
         12'h304: s[I_MIE]     = 1'b1;
         12'h305: s[I_MTVEC]   = 1'b1;
         12'h340: s[I_MSCR]    = 1'b1;
         12'h341: s[I_MEPC]    = 1'b1;
         12'h342: s[I_MCAUSE]  = 1'b1;
         12'hB00: s[I_MCYCLE]  = 1'b1;
         12'hB80: s[I_MCYCLEH] = 1'b1;
         default: s = '0;
      endcase
      return s;
   endfunction

   // Writes coinciding with reset are dropped, so they never bypass.
   assign w_cwe = bus.clint_wr_en_i & ~sys_reset;
   assign w_ewe = bus.ex_wr_en_i & ~sys_reset;
   assign w_ca  = bus.clint_wr_addr_i[11:0];
   assign w_ea  = bus.ex_wr_addr_i[11:0];
   assign w_ra  = bus.ex_rd_addr_i[11:0];
   assign w_cd  = bus.clint_wr_data_i;
   assign w_ed  = bus.ex_wr_data_i;

   assign w_unused_hi = ^{bus.ex_wr_addr_i[31:12],
                          bus.clint_wr_addr_i[31:12],
                          bus.ex_rd_addr_i[31:12]};

   assign w_c_sel = w_cwe ? f_dec(w_ca) : '0;
   assign w_e_sel = w_ewe ? f_dec(w_ea) : '0;
   assign w_rsel  = f_dec(w_ra);

   // Value each register holds after this edge (counting aside);
   // clint is applied last so it wins on a shared address.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         w_byp[i] = r_csr[i];
         if (w_e_sel[i]) w_byp[i] = w_ed;
         if (w_c_sel[i]) w_byp[i] = w_cd;
      end
      w_byp[I_MEPC][1:0] = 2'b00;
   end

   always_comb begin
      w_rd = '0;
      for (int i = 0; i < NREG; i++)
         if (w_rsel[i]) w_rd = w_byp[i];
   end

   assign w_lo_wr = w_c_sel[I_MCYCLE] | w_e_sel[I_MCYCLE];
   assign w_hi_wr = w_c_sel[I_MCYCLEH] | w_e_sel[I_MCYCLEH];
   assign w_carry = ~w_lo_wr & (&r_csr[I_MCYCLE]);

   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         for (int i = 0; i < NREG; i++)
            r_csr[i] <= '0;
         r_csr[I_MSTATUS] <= MSTATUS_RST;
         r_priv           <= 2'b11;
      end else begin
         for (int i = 0; i < NREG; i++)
            r_csr[i] <= w_byp[i];
         if (!w_lo_wr)
            r_csr[I_MCYCLE] <= r_csr[I_MCYCLE] + 32'd1;
         if (!w_hi_wr)
            r_csr[I_MCYCLEH] <= r_csr[I_MCYCLEH]
                                + {31'd0, w_carry};
         // 2'b10 is reserved and leaves the level unchanged.
         if (bus.clint_wr_privilege_en_i &&
             bus.clint_wr_privilege_ctrl_i != 2'b10)
            r_priv <= bus.clint_wr_privilege_ctrl_i;
      end
   end

   assign bus.ex_rd_data_o    = w_rd;
   assign bus.clint_mtvec_o   = w_byp[I_MTVEC];
   assign bus.clint_mepc_o    = w_byp[I_MEPC];
   assign bus.clint_mstatus_o = w_byp[I_MSTATUS];
   assign bus.global_int_en_o = w_byp[I_MSTATUS][3];
   assign bus.privilege_o     = r_priv;
endmodule

// File: tb/tb_csr_reg.sv
// tb_csr_reg: random and directed stimulus for csr_reg,
// checked against an address-keyed behavioural model.
module tb_csr_reg;
   logic sys_clk = 1'b0;
   logic sys_reset;

   csr_reg_if bus ();

   csr_reg dut (
      .sys_clk   (sys_clk),
      .sys_reset (sys_reset),
      .bus       (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [11:0] adr_tab [10];
   logic [31:0] m_csr [logic [11:0]];
   logic [63:0] m_cnt;
   logic [1:0]  m_priv;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_csr.delete();
      for (int i = 0; i < 6; i++) m_csr[adr_tab[i]] = 32'h0;
      m_csr[12'h300] = 32'h0000_1800;
      m_cnt  = 64'h0;
      m_priv = 2'b11;
   endtask

   function automatic logic m_impl(input logic [11:0] a);
      return m_csr.exists(a) || a == 12'hB00 || a == 12'hB80;
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      if (a == 12'hB00) return m_cnt[31:0];
      if (a == 12'hB80) return m_cnt[63:32];
      if (m_csr.exists(a)) return m_csr[a];
      return 32'h0;
   endfunction

   function automatic logic m_wrote(input logic [11:0] a);
      if (sys_reset || !m_impl(a)) return 1'b0;
      return (bus.ex_wr_en_i && bus.ex_wr_addr_i[11:0] == a) ||
             (bus.clint_wr_en_i && bus.clint_wr_addr_i[11:0] == a);
   endfunction

   function automatic logic [31:0] m_pend(input logic [11:0] a);
      logic [31:0] v;
      v = m_read(a);
      if (m_wrote(a)) begin
         if (bus.ex_wr_en_i && bus.ex_wr_addr_i[11:0] == a)
            v = bus.ex_wr_data_i;
         if (bus.clint_wr_en_i && bus.clint_wr_addr_i[11:0] == a)
            v = bus.clint_wr_data_i;
         if (a == 12'h341) v = v & ~32'h3;
      end
      return v;
   endfunction

   task automatic commit();
      logic [31:0] nv [6];
      logic [31:0] lo, hi;
      logic        lw, hw;
      for (int i = 0; i < 6; i++) nv[i] = m_pend(adr_tab[i]);
      lw = m_wrote(12'hB00);
      hw = m_wrote(12'hB80);
      lo = m_pend(12'hB00);
      hi = m_pend(12'hB80);
      if (!lw && !hw)  m_cnt = m_cnt + 64'd1;
      else if (!hw)    m_cnt = {m_cnt[63:32], lo};
      else if (!lw)    m_cnt = {hi, m_cnt[31:0] + 32'd1};
      else             m_cnt = {hi, lo};
      for (int i = 0; i < 6; i++) m_csr[adr_tab[i]] = nv[i];
      if (bus.clint_wr_privilege_en_i &&
          bus.clint_wr_privilege_ctrl_i != 2'b10)
         m_priv = bus.clint_wr_privilege_ctrl_i;
   endtask

   task automatic check_outputs();
      logic [31:0] ms;
      ms = m_pend(12'h300);
      check("ex_rd", bus.ex_rd_data_o,
            m_pend(bus.ex_rd_addr_i[11:0]));
      check("mtvec", bus.clint_mtvec_o, m_pend(12'h305));
      check("mepc", bus.clint_mepc_o, m_pend(12'h341));
      check("mstatus", bus.clint_mstatus_o, ms);
      check("gie", {31'd0, bus.global_int_en_o}, {31'd0, ms[3]});
      check("priv", {30'd0, bus.privilege_o}, {30'd0, m_priv});
   endtask

   task automatic drive(input logic cwe, input logic [31:0] ca,
                        input logic [31:0] cd, input logic ewe,
                        input logic [31:0] ea, input logic [31:0] ed,
                        input logic [31:0] ra, input logic pe,
                        input logic [1:0] pc);
      bus.clint_wr_en_i             = cwe;
      bus.clint_wr_addr_i           = ca;
      bus.clint_wr_data_i           = cd;
      bus.ex_wr_en_i                = ewe;
      bus.ex_wr_addr_i              = ea;
      bus.ex_wr_data_i              = ed;
      bus.ex_rd_addr_i              = ra;
      bus.clint_wr_privilege_en_i   = pe;
      bus.clint_wr_privilege_ctrl_i = pc;
   endtask

   // Entered and left on a falling edge.
   task automatic cycle(input logic cwe, input logic [31:0] ca,
                        input logic [31:0] cd, input logic ewe,
                        input logic [31:0] ea, input logic [31:0] ed,
                        input logic [31:0] ra, input logic pe,
                        input logic [1:0] pc);
      drive(cwe, ca, cd, ewe, ea, ed, ra, pe, pc);
      #1;
      check_outputs();
      @(posedge sys_clk);
      if (!sys_reset) commit();
      @(negedge sys_clk);
   endtask

   task automatic idle(input logic [31:0] ra);
      cycle(0, 0, 0, 0, 0, 0, ra, 0, 2'b00);
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] r;
      r = $urandom;
      return {r[31:12], adr_tab[$urandom_range(0, 9)]};
   endfunction

   function automatic logic [31:0] rnd_data();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
      return r;
   endfunction

   initial begin
      adr_tab = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'hB00, 12'hB80, 12'h301, 12'hC00};
      sys_reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 32'h300, 0, 2'b00);
      model_reset();
      #1;
      check_outputs();
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_reset = 1'b0;

      // Reset state of every address, counter running.
      idle(32'hB00);
      drive(0, 0, 0, 0, 0, 0, 32'hB00, 0, 2'b00);
      #1;
      check("mcycle_first", bus.ex_rd_data_o, 32'd1);
      for (int i = 0; i < 10; i++)
         idle({20'hABCDE, adr_tab[i]});

      // ex write of mtvec is visible in the write cycle.
      drive(0, 0, 0, 1, 32'h305, 32'h8000_0100, 32'h305, 0, 2'b00);
      #1;
      check("mtvec_byp_rd", bus.ex_rd_data_o, 32'h8000_0100);
      check("mtvec_byp", bus.clint_mtvec_o, 32'h8000_0100);
      cycle(0, 0, 0, 1, 32'h305, 32'h8000_0100, 32'h305, 0, 2'b00);
      idle(32'h305);

      // Same-address collision: clint wins, mepc low bits cleared.
      drive(1, 32'h341, 32'h2222_2223, 1, 32'h341, 32'h1111_1111,
            32'h341, 0, 2'b00);
      #1;
      check("mepc_prio_byp", bus.clint_mepc_o, 32'h2222_2220);
      cycle(1, 32'h341, 32'h2222_2223, 1, 32'h341, 32'h1111_1111,
            32'h341, 0, 2'b00);
      drive(0, 0, 0, 0, 0, 0, 32'h341, 0, 2'b00);
      #1;
      check("mepc_prio", bus.ex_rd_data_o, 32'h2222_2220);

      // Counter carry across the 32-bit boundary.
      cycle(0, 0, 0, 1, 32'hB80, 32'h0, 32'hB80, 0, 2'b00);
      cycle(0, 0, 0, 1, 32'hB00, 32'hFFFF_FFFE, 32'hB00, 0, 2'b00);
      idle(32'hB00);
      idle(32'hB00);
      drive(0, 0, 0, 0, 0, 0, 32'hB00, 0, 2'b00);
      #1;
      check("mcycle_wrap", bus.ex_rd_data_o, 32'h0);
      idle(32'hB80);
      drive(0, 0, 0, 0, 0, 0, 32'hB80, 0, 2'b00);
      #1;
      check("mcycleh_carry", bus.ex_rd_data_o, 32'h1);

      // Privilege updates, reserved encoding ignored.
      cycle(0, 0, 0, 0, 0, 0, 32'h300, 1, 2'b00);
      #1;
      check("priv_m_to_u", {30'd0, bus.privilege_o}, 32'd0);
      cycle(0, 0, 0, 0, 0, 0, 32'h300, 1, 2'b10);
      #1;
      check("priv_reserved", {30'd0, bus.privilege_o}, 32'd0);
      cycle(0, 0, 0, 0, 0, 0, 32'h300, 1, 2'b11);
      #1;
      check("priv_u_to_m", {30'd0, bus.privilege_o}, 32'd3);

      // Global interrupt enable follows a pending mstatus write.
      drive(1, 32'h300, 32'h0000_0008, 0, 0, 0, 32'h300, 0, 2'b00);
      #1;
      check("gie_byp", {31'd0, bus.global_int_en_o}, 32'd1);
      cycle(1, 32'h300, 32'h0000_0008, 0, 0, 0, 32'h300, 0, 2'b00);
      cycle(0, 0, 0, 0, 0, 0, 32'hB00, 1, 2'b00);

      // Asynchronous reset mid-run, with writes held during reset.
      drive(0, 0, 0, 0, 0, 0, 32'hB00, 0, 2'b00);
      @(posedge sys_clk);
      commit();
      #3;
      sys_reset = 1'b1;
      model_reset();
      #1;
      check("rst_mcycle", bus.ex_rd_data_o, 32'h0);
      check("rst_mstatus", bus.clint_mstatus_o, 32'h0000_1800);
      check("rst_mtvec", bus.clint_mtvec_o, 32'h0);
      check("rst_priv", {30'd0, bus.privilege_o}, 32'd3);
      check("rst_gie", {31'd0, bus.global_int_en_o}, 32'd0);
      @(negedge sys_clk);
      drive(1, 32'h300, 32'h8, 1, 32'h340, 32'hDEAD_BEEF,
            32'h340, 1, 2'b00);
      #1;
      check_outputs();
      @(negedge sys_clk);
      sys_reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 32'h340, 0, 2'b00);
      #1;
      check("rst_wr_drop", bus.ex_rd_data_o, 32'h0);
      idle(32'h340);

      // Random traffic on both ports.
      for (int n = 0; n < 600; n++) begin
         logic        cwe, ewe, pe;
         logic [31:0] ca, ea;
         cwe = ($urandom_range(0, 2) == 0);
         ewe = ($urandom_range(0, 1) == 0);
         pe  = ($urandom_range(0, 4) == 0);
         ca  = rnd_addr();
         ea  = ($urandom_range(0, 3) == 0) ? ca : rnd_addr();
         cycle(cwe, ca, rnd_data(), ewe, ea, rnd_data(),
               ($urandom_range(0, 2) == 0) ? ea : rnd_addr(),
               pe, 2'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
